// File: rtl/hazard_unit_sb.sv
// hazard_unit_sb
// Pipeline hazard unit for the 5-stage RISC-V core, with a register scoreboard
// for one non-pipelined long-latency unit (mul/div).
//
// The long unit writes back through its own register-file port. It never
// passes through M/W.
//
// Ports:
//   clk, resetn                     clock (rising edge) and async active-low reset
//   Rs1D, Rs2D, RdD, LongOpD        Decode-stage register fields and long-op flag
//   ResultSrcE, PCSrcE              Execute result select (bit 0 = load) and taken branch/jump
//   Rs1E, Rs2E, RdE, LongOpE        Execute-stage register fields and valid long op
//   RegWriteM, RdM                  Memory-stage write enable and destination
//   RegWriteW, RdW                  Writeback-stage write enable and destination
//   StallF, StallD                  hold PC and IF/ID
//   FlushD, FlushE                  clear IF/ID and ID/EX
//   ForwardAE, ForwardBE            Execute operand select: 00 RF, 01 W, 10 M, 11 long unit
//   ForwardRD1, ForwardRD2          bypass the W result into Decode operands
//   LongBusy, LongDone, LongRd      long-unit occupancy, completion pulse, in-flight destination
module hazard_unit_sb #(
    parameter int REG_ADDR_W = 5,
    parameter int LONG_LAT   = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  LongOpD,
    input  logic [1:0]            ResultSrcE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  LongOpE,
    input  logic                  RegWriteM,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteW,
    input  logic [REG_ADDR_W-1:0] RdW,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  ForwardRD1,
    output logic                  ForwardRD2,
    output logic                  LongBusy,
    output logic                  LongDone,
    output logic [REG_ADDR_W-1:0] LongRd
);

    localparam int NumRegs = 2 ** REG_ADDR_W;

    logic [NumRegs-1:0]    pendReg;
    logic [NumRegs-1:0]    pendNext;
    // Pending bits as seen by Decode: an entry retiring this cycle no longer blocks.
    logic [NumRegs-1:0]    pendEff;
    logic [CNT_W-1:0]      cntReg;
    logic [REG_ADDR_W-1:0] longRdReg;
    logic                  issue;
    logic                  lwStall;
    logic                  sbStall;
    logic                  structStall;
    logic                  stall;
    logic                  unusedResultSrc;

    // Only bit 0 of ResultSrcE (load) matters to hazard detection.
    assign unusedResultSrc = ResultSrcE[1];

    // A long op squashed by a taken branch, or one targeting x0, never occupies the scoreboard.
    assign issue    = LongOpE & ~PCSrcE & (RdE != '0);
    assign LongDone = (cntReg == CNT_W'(1));
    // LongOpE is included so a long op in Decode sees the unit busy in the issue cycle.
    assign LongBusy = (cntReg != '0) | LongOpE;
    assign LongRd   = longRdReg;

    genvar gi;
    generate
        for (gi = 0; gi < NumRegs; gi++) begin : g_pendEff
            assign pendEff[gi] = pendReg[gi] & ~(LongDone & (longRdReg == REG_ADDR_W'(gi)));
        end
    endgenerate

    always_comb begin
        pendNext = pendReg;
        if (LongDone) begin
            pendNext[longRdReg] = 1'b0;
        end
        // The set is applied after the clear, so a same-cycle issue keeps its bit.
        if (issue) begin
            pendNext[RdE] = 1'b1;
        end
        pendNext[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pendReg   <= '0;
            cntReg    <= '0;
            longRdReg <= '0;
        end else begin
            pendReg <= pendNext;
            if (issue) begin
                cntReg    <= CNT_W'(LONG_LAT);
                longRdReg <= RdE;
            end else if (cntReg != '0) begin
                cntReg <= cntReg - CNT_W'(1);
            end
        end
    end

    // The pend[RdD] term blocks WAW against the in-flight long op.
    assign lwStall     = ResultSrcE[0] & (RdE != '0) & ((Rs1D == RdE) | (Rs2D == RdE));
    assign sbStall     = pendEff[Rs1D] | pendEff[Rs2D] | pendEff[RdD];
    assign structStall = LongOpD & LongBusy & ~LongDone;
    assign stall       = lwStall | sbStall | structStall;

    assign StallF = stall;
    assign StallD = stall;
    assign FlushD = PCSrcE;
    assign FlushE = stall | PCSrcE;

    // Execute forwarding priority: M (youngest) first, then the long-unit result, then W.
    logic [REG_ADDR_W-1:0] rsE  [2];
    logic [1:0]            fwdE [2];
    assign rsE[0] = Rs1E;
    assign rsE[1] = Rs2E;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwdE
            assign fwdE[gi] = (rsE[gi] == '0)                         ? 2'b00 :
                              (RegWriteM && (RdM == rsE[gi]))         ? 2'b10 :
                              (LongDone && (longRdReg == rsE[gi]))    ? 2'b11 :
                              (RegWriteW && (RdW == rsE[gi]))         ? 2'b01 :
                                                                        2'b00;
        end
    endgenerate

    assign ForwardAE = fwdE[0];
    assign ForwardBE = fwdE[1];

    assign ForwardRD1 = RegWriteW & (RdW == Rs1D) & (RdW != '0);
    assign ForwardRD2 = RegWriteW & (RdW == Rs2D) & (RdW != '0);

endmodule

// File: tb/tb_hazard_unit_sb.sv
module tb_hazard_unit_sb;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          LongOpD, PCSrcE, LongOpE, RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          StallF, StallD, FlushD, FlushE, ForwardRD1, ForwardRD2;
    logic          LongBusy, LongDone;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [AW-1:0] LongRd;

    int passCnt  = 0;
    int totalCnt = 0;

    hazard_unit_sb #(.REG_ADDR_W(AW), .LONG_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .resetn(resetn),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .LongOpD(LongOpD),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LongOpE(LongOpE),
        .RegWriteM(RegWriteM), .RdM(RdM), .RegWriteW(RegWriteW), .RdW(RdW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardRD1(ForwardRD1), .ForwardRD2(ForwardRD2),
        .LongBusy(LongBusy), .LongDone(LongDone), .LongRd(LongRd)
    );

    always #5 clk = ~clk;

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; LongOpD = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0; LongOpE = 1'b0;
        RegWriteM = 1'b0; RdM = '0; RegWriteW = 1'b0; RdW = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (LAT + 1) tick();
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        logic        sawDone;
        resetn = 1'b0;
        idle();
        #3;
        outs = {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, ForwardRD1, ForwardRD2, LongBusy, LongDone};
        totalCnt++;
        if (outs !== 12'h000) $display("FAIL reset_outputs got=%h want=000", outs);
        else passCnt++;
        totalCnt++;
        if (LongRd !== '0) $display("FAIL reset_longrd got=%0d want=0", LongRd);
        else passCnt++;
        $display("reset: outputs=%h LongRd=%0d", outs, LongRd);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        LongOpE = 1'b1; RdE = 5'd7;
        tick();
        idle();
        tick();
        #1;
        totalCnt++;
        if (LongBusy !== 1'b1) $display("FAIL reset_busy_before got=%b want=1", LongBusy);
        else passCnt++;
        resetn = 1'b0;
        #1;
        totalCnt++;
        if ({LongBusy, LongDone, LongRd} !== {2'b00, 5'd0})
            $display("FAIL reset_midop got busy=%b done=%b rd=%0d want 0 0 0", LongBusy, LongDone, LongRd);
        else passCnt++;
        tick();
        @(negedge clk);
        resetn = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            if (LongDone === 1'b1 || LongBusy === 1'b1) sawDone = 1'b1;
        end
        totalCnt++;
        if (sawDone !== 1'b0) $display("FAIL reset_no_done got=%b want=0", sawDone);
        else passCnt++;
        Rs1D = 5'd7;
        #1;
        totalCnt++;
        if (StallD !== 1'b0) $display("FAIL reset_pend_clear got=%b want=0", StallD);
        else passCnt++;
        $display("reset mid-op: no LongDone seen=%b, stall on x7=%b", ~sawDone, StallD);
        idle();
    endtask

    task automatic test_load_use();
        idle();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs1D = 5'd5;
        #1;
        totalCnt++;
        if ({StallF, StallD, FlushE, FlushD} !== 4'b1110)
            $display("FAIL loaduse_rs1 got=%b want=1110", {StallF, StallD, FlushE, FlushD});
        else passCnt++;
        tick();
        ResultSrcE = 2'b00; RdE = '0;
        #1;
        totalCnt++;
        if ({StallF, StallD, FlushE} !== 3'b000)
            $display("FAIL loaduse_release got=%b want=000", {StallF, StallD, FlushE});
        else passCnt++;
        idle();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5;
        #1;
        totalCnt++;
        if (StallD !== 1'b1) $display("FAIL loaduse_rs2 got=%b want=1", StallD);
        else passCnt++;
        idle();
        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        #1;
        totalCnt++;
        if ({StallD, FlushE} !== 2'b00) $display("FAIL loaduse_x0 got=%b want=00", {StallD, FlushE});
        else passCnt++;
        idle();
        ResultSrcE = 2'b10; RdE = 5'd5; Rs1D = 5'd5;
        #1;
        totalCnt++;
        if (StallD !== 1'b0) $display("FAIL loaduse_notload got=%b want=0", StallD);
        else passCnt++;
        $display("load-use: vectors applied, passed so far %0d", passCnt);
        idle();
    endtask

    task automatic test_long_stall();
        idle();
        tick();
        LongOpE = 1'b1; RdE = 5'd7;
        #1;
        totalCnt++;
        if ({LongBusy, StallD} !== 2'b10) $display("FAIL long_issue got=%b want=10", {LongBusy, StallD});
        else passCnt++;
        tick();
        idle();
        Rs1D = 5'd7;
        for (int c = 1; c <= 3; c++) begin
            #1;
            totalCnt++;
            if ({StallD, LongDone} !== 2'b10)
                $display("FAIL long_stall_c%0d got=%b want=10", c, {StallD, LongDone});
            else passCnt++;
            tick();
        end
        #1;
        totalCnt++;
        if ({StallD, LongDone, LongRd} !== {2'b01, 5'd7})
            $display("FAIL long_done got stall=%b done=%b rd=%0d want 0 1 7", StallD, LongDone, LongRd);
        else passCnt++;
        tick();
        Rs1E = 5'd7;
        #1;
        totalCnt++;
        if ({ForwardAE, StallD, LongBusy, LongDone} !== 5'b00000)
            $display("FAIL long_after got=%b want=00000", {ForwardAE, StallD, LongBusy, LongDone});
        else passCnt++;
        RegWriteW = 1'b1; RdW = 5'd7;
        #1;
        totalCnt++;
        if (ForwardAE !== 2'b01) $display("FAIL long_after_w got=%b want=01", ForwardAE);
        else passCnt++;
        $display("long stall: x7 held 3 cycles, released at LongDone");
        idle();
    endtask

    task automatic test_long_forward();
        idle();
        LongOpE = 1'b1; RdE = 5'd9;
        tick();
        idle();
        repeat (LAT - 1) tick();
        Rs2E = 5'd9;
        #1;
        totalCnt++;
        if ({LongDone, ForwardBE} !== 3'b111) $display("FAIL lfwd_long got=%b want=111", {LongDone, ForwardBE});
        else passCnt++;
        RegWriteW = 1'b1; RdW = 5'd9;
        #1;
        totalCnt++;
        if (ForwardBE !== 2'b11) $display("FAIL lfwd_over_w got=%b want=11", ForwardBE);
        else passCnt++;
        RegWriteM = 1'b1; RdM = 5'd9;
        #1;
        totalCnt++;
        if (ForwardBE !== 2'b10) $display("FAIL lfwd_m_wins got=%b want=10", ForwardBE);
        else passCnt++;
        tick();
        RegWriteM = 1'b0;
        #1;
        totalCnt++;
        if (ForwardBE !== 2'b01) $display("FAIL lfwd_w_next got=%b want=01", ForwardBE);
        else passCnt++;
        RegWriteM = 1'b1; RdM = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdW = 5'd0;
        #1;
        totalCnt++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) $display("FAIL fwd_x0 got=%b want=0000", {ForwardAE, ForwardBE});
        else passCnt++;
        idle();
        RegWriteM = 1'b1; RdM = 5'd3; RegWriteW = 1'b1; RdW = 5'd4; Rs1E = 5'd4; Rs2E = 5'd3;
        #1;
        totalCnt++;
        if ({ForwardAE, ForwardBE} !== 4'b0110) $display("FAIL fwd_mw got=%b want=0110", {ForwardAE, ForwardBE});
        else passCnt++;
        $display("long forward: ForwardBE paths 11/10/01 exercised");
        drain();
    endtask

    task automatic test_struct();
        idle();
        LongOpE = 1'b1; RdE = 5'd4;
        tick();
        idle();
        tick();
        LongOpD = 1'b1; RdD = 5'd10;
        for (int c = 3; c >= 2; c--) begin
            #1;
            totalCnt++;
            if (StallD !== 1'b1) $display("FAIL struct_stall_cnt%0d got=%b want=1", c, StallD);
            else passCnt++;
            tick();
        end
        #1;
        totalCnt++;
        if ({StallD, LongDone} !== 2'b01) $display("FAIL struct_release got=%b want=01", {StallD, LongDone});
        else passCnt++;
        tick();
        idle();
        LongOpE = 1'b1; RdE = 5'd10;
        tick();
        idle();
        Rs1D = 5'd4;
        #1;
        totalCnt++;
        if ({StallD, LongRd} !== {1'b0, 5'd10}) $display("FAIL struct_old_clear got stall=%b rd=%0d want 0 10", StallD, LongRd);
        else passCnt++;
        Rs1D = 5'd0; RdD = 5'd10;
        #1;
        totalCnt++;
        if (StallD !== 1'b1) $display("FAIL struct_waw got=%b want=1", StallD);
        else passCnt++;
        $display("structural: second long op waited, pend holds x10 only");
        drain();
    endtask

    task automatic test_branch_flush();
        idle();
        PCSrcE = 1'b1; LongOpE = 1'b1; RdE = 5'd3;
        #1;
        totalCnt++;
        if ({FlushD, FlushE} !== 2'b11) $display("FAIL br_flush got=%b want=11", {FlushD, FlushE});
        else passCnt++;
        tick();
        idle();
        Rs1D = 5'd3;
        #1;
        totalCnt++;
        if ({LongBusy, StallD} !== 2'b00) $display("FAIL br_no_issue got=%b want=00", {LongBusy, StallD});
        else passCnt++;
        LongOpE = 1'b1; RdE = 5'd0;
        tick();
        idle();
        #1;
        totalCnt++;
        if (LongBusy !== 1'b0) $display("FAIL x0_no_issue got=%b want=0", LongBusy);
        else passCnt++;
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd8; Rs2D = 5'd8;
        #1;
        totalCnt++;
        if ({FlushD, FlushE, StallD} !== 3'b111) $display("FAIL br_and_stall got=%b want=111", {FlushD, FlushE, StallD});
        else passCnt++;
        $display("branch flush: squashed long op left scoreboard empty");
        idle();
    endtask

    task automatic test_decode_bypass();
        idle();
        RegWriteW = 1'b1; RdW = 5'd6; Rs1D = 5'd6; Rs2D = 5'd6;
        #1;
        totalCnt++;
        if ({ForwardRD1, ForwardRD2} !== 2'b11) $display("FAIL byp_both got=%b want=11", {ForwardRD1, ForwardRD2});
        else passCnt++;
        Rs1D = 5'd1;
        #1;
        totalCnt++;
        if ({ForwardRD1, ForwardRD2} !== 2'b01) $display("FAIL byp_rs2 got=%b want=01", {ForwardRD1, ForwardRD2});
        else passCnt++;
        RdW = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        totalCnt++;
        if ({ForwardRD1, ForwardRD2} !== 2'b00) $display("FAIL byp_x0 got=%b want=00", {ForwardRD1, ForwardRD2});
        else passCnt++;
        RegWriteW = 1'b0; RdW = 5'd6; Rs1D = 5'd6;
        #1;
        totalCnt++;
        if (ForwardRD1 !== 1'b0) $display("FAIL byp_nowrite got=%b want=0", ForwardRD1);
        else passCnt++;
        $display("decode bypass: both operands checked");
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_long_stall();
        test_long_forward();
        test_struct();
        test_branch_flush();
        test_decode_bypass();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
- Parametrised successor to the pipeline hazard unit for the 5-stage RISC-V core.
- Keeps the existing behaviour: load-use stall, branch flush, M/W forwarding into Execute, W-to-Decode bypass.
- Adds a register scoreboard and an internal latency counter for one non-pipelined long-latency unit (mul/div) that writes back through a dedicated register-file port.
- Adds a forwarding path from the long-unit result and a W-to-Decode bypass on both source operands.

Parameters:
- REG_ADDR_W, 5, register address width; the register count is 2**REG_ADDR_W and register 0 is hardwired to zero.
- LONG_LAT, 4, cycles from long-op issue in Execute to long-unit result valid; legal range 2..15.
- CNT_W, 4, latency counter width; must satisfy 2**CNT_W > LONG_LAT.

Ports:
- clk  in  1  core clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- Rs1D  in  REG_ADDR_W  Decode source register 1.
- Rs2D  in  REG_ADDR_W  Decode source register 2.
- RdD  in  REG_ADDR_W  Decode destination register.
- LongOpD  in  1  instruction in Decode is a long-latency op.
- ResultSrcE  in  2  Execute result select; bit 0 set means load.
- PCSrcE  in  1  branch or jump taken in Execute.
- Rs1E  in  REG_ADDR_W  Execute source register 1.
- Rs2E  in  REG_ADDR_W  Execute source register 2.
- RdE  in  REG_ADDR_W  Execute destination register.
- LongOpE  in  1  valid long-latency op in Execute.
- RegWriteM  in  1  Memory-stage register write enable.
- RdM  in  REG_ADDR_W  Memory-stage destination register.
- RegWriteW  in  1  Writeback-stage register write enable.
- RdW  in  REG_ADDR_W  Writeback-stage destination register.
- StallF  out  1  hold PC.
- StallD  out  1  hold the IF/ID register.
- FlushD  out  1  clear the IF/ID register.
- FlushE  out  1  clear the ID/EX register.
- ForwardAE  out  2  Execute operand A select: 00 register file, 01 W, 10 M, 11 long-unit result.
- ForwardBE  out  2  Execute operand B select, same encoding.
- ForwardRD1  out  1  bypass the W result to Decode operand 1.
- ForwardRD2  out  1  bypass the W result to Decode operand 2.
- LongBusy  out  1  long unit occupied.
- LongDone  out  1  one-cycle pulse: long result valid and written back this cycle.
- LongRd  out  REG_ADDR_W  destination register of the in-flight long op.

Behaviour:
- Scoreboard: pend[2**REG_ADDR_W-1:0].
  - Issue = LongOpE & ~PCSrcE & (RdE != 0). On issue: pend[RdE] <= 1, LongRd <= RdE, cnt <= LONG_LAT.
  - While cnt != 0: cnt decrements every cycle.
  - LongDone = (cnt == 1). On LongDone: pend[LongRd] <= 0.
  - LongBusy = (cnt != 0) | LongOpE.
  - pend[0] is always 0.
- Reset (resetn low, asynchronous):
  - pend all 0, cnt = 0, LongRd = 0.
  - LongBusy = 0 and LongDone = 0 while LongOpE = 0 and the other inputs are idle.
  - All stalls, flushes and forward selects are then 0.
  - Reset mid-operation abandons the in-flight op without a LongDone pulse.
- Same-cycle issue and done:
  - Not possible under legal stimulus, because a long op in Decode stalls while LongBusy.
  - If it occurs anyway, the set to pend[RdE] wins over the clear.
- Stall terms (all combinational):
  - lwStall = ResultSrcE[0] & (RdE != 0) & (Rs1D == RdE | Rs2D == RdE).
  - sbStall = pend[Rs1D] | pend[Rs2D] | pend[RdD], where pend[RdD] covers WAW; a pending bit being cleared by LongDone this cycle does not stall.
  - structStall = LongOpD & LongBusy & ~LongDone.
  - stall = lwStall | sbStall | structStall.
- Stall and flush outputs:
  - StallF = StallD = stall.
  - FlushE = stall | PCSrcE.
  - FlushD = PCSrcE. If PCSrcE and stall coincide, the flush still applies and StallD has no effect on the flushed content.
- ForwardAE priority (ForwardBE identical, using Rs2E), for Rs1E != 0:
  - 10 if RegWriteM & RdM == Rs1E;
  - else 11 if LongDone & LongRd == Rs1E;
  - else 01 if RegWriteW & RdW == Rs1E;
  - else 00.
- Decode bypass:
  - ForwardRD1 = RegWriteW & (RdW == Rs1D) & (RdW != 0).
  - ForwardRD2 = RegWriteW & (RdW == Rs2D) & (RdW != 0).
- Long results never reach M/W; they are written only via the dedicated port when LongDone is high.

Test Plan:
- Reset with LongOpE=0: hold resetn low mid-count, release -> LongBusy=0, cnt=0, all outputs 0, no LongDone pulse.
- Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for exactly one cycle. Same with RdE=0 -> no stall.
- Long op x7 issued, LONG_LAT=4; next instruction reads x7 in Decode -> StallD high for 3 cycles, released in the LongDone cycle. In the following cycle ForwardAE=01 if the register write has not settled, else 00.
- Long-unit forward: LongDone with LongRd=9, Rs2E=9, RegWriteM=0 -> ForwardBE=11. With RegWriteM=1 and RdM=9 -> ForwardBE=10.
- Structural: second LongOpD while cnt=3 -> stall until LongDone. Issue then proceeds, and pend holds only the new RdE.
- Branch flush with long op in Execute: PCSrcE=1, LongOpE=1, RdE=3 -> FlushD=FlushE=1, pend[3] stays 0, cnt stays 0.
